l1_beam_scaler_v3: RTL and testbench

L1_BEAM_SCALER_V3 -- requirements
Module: l1_beam_scaler_v3

---
 rtl/l1_beam_scaler_v3.sv | 184 ++++++++++++++++++
 tb/tb_l1_beam_scaler_v3.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_beam_scaler_v3.sv
// Per-beam trigger scalers with double-banked period snapshots behind a Wishbone target.
// Optional per-bit holdoff is compiled in with `define L1_SCALER_HOLDOFF_EN.
module l1_beam_scaler_v3 #(
    parameter int NBEAMS       = 48,
    parameter int NLEVELS      = 2,
    parameter int COUNT_BITS   = 16,
    parameter int HOLDOFF_BITS = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [11:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    output logic                      wb_ack_o,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    input  logic [NLEVELS*NBEAMS-1:0] trig_i,
    output logic [NBEAMS-1:0]         trigger_o,
    output logic                      count_done_o,
    output logic                      bank_o
);
    localparam int NT = NLEVELS * NBEAMS;
    localparam int NW = (NBEAMS + 31) / 32;

    logic                  enable;
    logic [31:0]           period;
    logic [31:0]           timer;
    logic [7:0]            period_cnt;
    logic [NT-1:0]         mask;
    logic [NT-1:0]         trig_q;
    logic [NT-1:0]         evt;
    logic [NT-1:0]         hold_busy;
    logic [COUNT_BITS-1:0] live  [NT];
    logic [COUNT_BITS-1:0] bank0 [NT];
    logic [COUNT_BITS-1:0] bank1 [NT];

    logic        req;
    logic        wr;
    logic [9:0]  adr_w;
    logic        clear;
    logic        period_wr;
    logic        terminal;
    logic [31:0] period_wdata;
    logic [31:0] rdata;
    logic        unused_ok;

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] dat,
                                               input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = sel[b] ? dat[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    // An access is taken only while ack is low, so back-to-back strobes complete every other cycle.
    assign req          = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr           = req & wb_we_i;
    assign adr_w        = wb_adr_i[11:2];
    assign clear        = wr && (adr_w == 10'h000) && wb_sel_i[0] && wb_dat_i[1];
    assign period_wr    = wr && (adr_w == 10'h001);
    assign period_wdata = byte_merge(period, wb_dat_i, wb_sel_i);
    assign terminal     = (period != 32'd0) && (timer == period - 32'd1) && !clear;
    assign wb_err_o     = 1'b0;
    assign wb_rty_o     = 1'b0;
    assign unused_ok    = &{1'b0, wb_adr_i[1:0]};

`ifdef L1_SCALER_HOLDOFF_EN
    logic [HOLDOFF_BITS-1:0] holdoff;
    logic [HOLDOFF_BITS-1:0] hold_cnt [NT];
    logic [31:0]             holdoff_wdata;

    assign holdoff_wdata = byte_merge(32'(holdoff), wb_dat_i, wb_sel_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) holdoff <= '0;
        else if (wr && (adr_w == 10'h002)) holdoff <= holdoff_wdata[HOLDOFF_BITS-1:0];
    end

    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < NT; i++) begin
            if (wb_rst_i || clear) hold_cnt[i] <= '0;
            else if (evt[i]) hold_cnt[i] <= holdoff;
            else if (hold_cnt[i] != '0) hold_cnt[i] <= hold_cnt[i] - 1'b1;
        end
    end

    always_comb begin
        hold_busy = '0;
        for (int i = 0; i < NT; i++) hold_busy[i] = (hold_cnt[i] != '0);
    end
`else
    assign hold_busy = '0;
`endif

    assign evt = trig_i & ~trig_q & ~mask & {NT{enable}} & ~hold_busy;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            enable <= 1'b0;
            period <= '0;
            mask   <= '0;
        end else begin
            if (wr && (adr_w == 10'h000) && wb_sel_i[0]) enable <= wb_dat_i[0];
            if (period_wr) period <= period_wdata;
            for (int l = 0; l < NLEVELS; l++)
                for (int b = 0; b < NBEAMS; b++)
                    if (wr && (int'(adr_w) == 'h40 + l*NW + b/32) && wb_sel_i[(b%32)/8])
                        mask[l*NBEAMS+b] <= wb_dat_i[b%32];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            trig_q       <= '0;
            trigger_o    <= '0;
            count_done_o <= 1'b0;
            period_cnt   <= '0;
        end else begin
            trig_q       <= trig_i;
            trigger_o    <= evt[NBEAMS-1:0];
            count_done_o <= terminal;
            if (terminal) period_cnt <= period_cnt + 8'd1;
        end
    end

    // At terminal count the live counters land in the hidden bank, which then becomes readable;
    // an event in that same cycle seeds the new period instead of the snapshot.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            timer  <= '0;
            bank_o <= 1'b0;
            for (int i = 0; i < NT; i++) begin
                live[i]  <= '0;
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            if (period_wr || terminal || (period == 32'd0)) timer <= '0;
            else timer <= timer + 32'd1;
            if (terminal) begin
                bank_o <= ~bank_o;
                for (int i = 0; i < NT; i++) begin
                    if (bank_o) bank0[i] <= live[i];
                    else bank1[i] <= live[i];
                    live[i] <= evt[i] ? COUNT_BITS'(1) : '0;
                end
            end else begin
                for (int i = 0; i < NT; i++)
                    if (evt[i] && (live[i] != '1)) live[i] <= live[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (adr_w)
            10'h000: rdata[0] = enable;
            10'h001: rdata = period;
`ifdef L1_SCALER_HOLDOFF_EN
            10'h002: rdata = 32'(holdoff);
`endif
            10'h003: rdata = {16'h0000, period_cnt, 7'h00, bank_o};
            default: ;
        endcase
        for (int l = 0; l < NLEVELS; l++)
            for (int b = 0; b < NBEAMS; b++)
                if (int'(adr_w) == 'h40 + l*NW + b/32) rdata[b%32] = mask[l*NBEAMS+b];
        for (int i = 0; i < NT; i++)
            if (int'(adr_w) == 'h200 + i) rdata[COUNT_BITS-1:0] = bank_o ? bank1[i] : bank0[i];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_l1_beam_scaler_v3.sv
// Directed bench for l1_beam_scaler_v3: bus reads are scored by a monitor against an expected queue.
module tb_l1_beam_scaler_v3;
    localparam int NB = 40;
    localparam int NL = 2;
    localparam int CB = 8;
    localparam int NT = NB * NL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [11:0]   adr = '0;
    logic [31:0]   wdat = '0;
    logic [3:0]    sel = '0;
    logic          ack;
    logic [31:0]   rdat;
    logic          err;
    logic          rty;
    logic [NT-1:0] trig = '0;
    logic [NB-1:0] trigger;
    logic          done;
    logic          bank;

    int checks = 0;
    int errors = 0;
    int trig_cnt [NB] = '{default: 0};

    logic [31:0] exp_q [$];
    bit          chk_q [$];
    string       name_q [$];

`ifdef L1_SCALER_HOLDOFF_EN
    localparam logic [31:0] EXP_HO_RD  = 32'd5;
    localparam logic [31:0] EXP_HO_CNT = 32'd2;
`else
    localparam logic [31:0] EXP_HO_RD  = 32'd0;
    localparam logic [31:0] EXP_HO_CNT = 32'd6;
`endif

    l1_beam_scaler_v3 #(.NBEAMS(NB), .NLEVELS(NL), .COUNT_BITS(CB), .HOLDOFF_BITS(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack), .wb_dat_o(rdat),
        .wb_err_o(err), .wb_rty_o(rty), .trig_i(trig), .trigger_o(trigger),
        .count_done_o(done), .bank_o(bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every ack pops one scoreboard entry; reads are compared.
    always @(negedge clk) begin
        logic [31:0] e;
        bit          c;
        string       n;
        if (ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = name_q.pop_front();
                if (c) check(n, rdat, e);
            end
        end
    end

    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) if (trigger[b]) trig_cnt[b]++;
    end

    task automatic wb_access(input bit w, input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [31:0] e, input string nm);
        bit got = 1'b0;
        exp_q.push_back(e);
        chk_q.push_back(!w);
        name_q.push_back(nm);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            check({nm, "_ack_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            void'(chk_q.pop_front());
            void'(name_q.pop_front());
        end
    endtask

    task automatic wb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_access(1'b1, a, d, s, 32'd0, "write");
    endtask

    task automatic wb_read(input logic [11:0] a, input logic [31:0] e, input string nm);
        wb_access(1'b0, a, 32'd0, 4'hF, e, nm);
    endtask

    task automatic pulse_vec(input logic [NT-1:0] v, input int n);
        repeat (n) begin
            @(posedge clk); #1 trig = v;
            @(posedge clk); #1 trig = '0;
        end
    endtask

    task automatic pulse(input int idx, input int n);
        logic [NT-1:0] v = '0;
        v[idx] = 1'b1;
        pulse_vec(v, n);
    endtask

    task automatic wait_done(input string nm, input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(nm, 32'(got), 32'd1);
    endtask

    initial begin
        int          base;
        logic [3:0]  pat;
        logic [NT-1:0] v;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_done_bank", {30'd0, done, bank}, 32'd0);
        check("rst_err_rty", {30'd0, err, rty}, 32'd0);
        rst = 1'b0;

        wb_read(12'h000, 32'd0, "rst_ctrl");
        wb_read(12'h004, 32'd0, "rst_period");
        wb_read(12'h008, 32'd0, "rst_holdoff");
        wb_read(12'h00C, 32'd0, "rst_status");
        wb_read(12'h800, 32'd0, "rst_scaler");

        wb_write(12'h004, 32'h12345678, 4'b0101);
        wb_read(12'h004, 32'h00340078, "period_bytesel");
        wb_write(12'h004, 32'd0, 4'hF);
        wb_write(12'h020, 32'hDEADBEEF, 4'hF);
        wb_read(12'h020, 32'd0, "unmapped_rd");
        wb_write(12'h104, 32'hFFFFFFFF, 4'hF);
        wb_read(12'h104, 32'h000000FF, "mask_l0_w1");
        wb_write(12'h104, 32'd0, 4'hF);
        wb_write(12'h008, 32'h00000105, 4'b0001);
        wb_read(12'h008, EXP_HO_RD, "holdoff_rd");
        wb_write(12'h008, 32'd0, 4'hF);

        // Ten pulses on level-0 beam 3 over a 100-cycle period.
        base = trig_cnt[3];
        wb_write(12'h000, 32'd1, 4'hF);
        wb_write(12'h004, 32'd100, 4'hF);
        @(posedge clk); #1 trig[3] = 1'b1;
        @(posedge clk); #1 trig[3] = 1'b0;
        check("trigger_latency", 32'(trigger[3]), 32'd1);
        pulse(3, 9);
        wait_done("done_p100", 200);
        check("bank_after_done", 32'(bank), 32'd1);
        wb_write(12'h004, 32'd0, 4'hF);
        wb_read(12'h80C, 32'd10, "beam3_count");
        wb_read(12'h8AC, 32'd0, "l1_beam3_zero");
        wb_read(12'h00C, 32'h00000101, "status_after_period");
        check("trigger_beam3_pulses", 32'(trig_cnt[3] - base), 32'd10);

        // Level-1 beam 0 masked, level-0 beam 0 unaffected.
        wb_write(12'h108, 32'd1, 4'hF);
        wb_write(12'h000, 32'd3, 4'hF);
        check("bank_after_clear", 32'(bank), 32'd0);
        wb_read(12'h00C, 32'h00000100, "status_after_clear");
        base = trig_cnt[0];
        wb_write(12'h004, 32'd50, 4'hF);
        v = '0;
        v[0] = 1'b1;
        v[NB] = 1'b1;
        pulse_vec(v, 3);
        wait_done("done_mask", 100);
        wb_write(12'h004, 32'd0, 4'hF);
        wb_read(12'h800, 32'd3, "l0_beam0_count");
        wb_read(12'h8A0, 32'd0, "l1_beam0_masked");
        check("trigger_beam0_pulses", 32'(trig_cnt[0] - base), 32'd3);
        wb_write(12'h108, 32'd0, 4'hF);

        // 300 edges into an 8-bit scaler.
        wb_write(12'h000, 32'd3, 4'hF);
        wb_write(12'h004, 32'd1000, 4'hF);
        pulse(5, 300);
        wait_done("done_sat", 1200);
        wb_write(12'h004, 32'd0, 4'hF);
        wb_read(12'h814, 32'h000000FF, "saturate_255");

        // Holdoff of 5 against edges two cycles apart.
        wb_write(12'h000, 32'd3, 4'hF);
        wb_write(12'h008, 32'd5, 4'hF);
        base = trig_cnt[7];
        wb_write(12'h004, 32'd100, 4'hF);
        pulse(7, 6);
        wait_done("done_holdoff", 200);
        wb_write(12'h004, 32'd0, 4'hF);
        wb_read(12'h81C, EXP_HO_CNT, "holdoff_count");
        check("holdoff_trigger_pulses", 32'(trig_cnt[7] - base), EXP_HO_CNT);
        wb_write(12'h008, 32'd0, 4'hF);

        // Edge landing exactly in the terminal-count cycle (20th edge after the PERIOD write).
        wb_write(12'h000, 32'd3, 4'hF);
        wb_write(12'h004, 32'd20, 4'hF);
        pulse(9, 2);
        repeat (15) @(posedge clk);
        #1 trig[9] = 1'b1;
        @(posedge clk); #1 trig[9] = 1'b0;
        check("done_at_terminal", 32'(done), 32'd1);
        check("bank_at_terminal", 32'(bank), 32'd1);
        wb_read(12'h824, 32'd2, "frozen_excludes_edge");
        wait_done("done_next_period", 40);
        wb_write(12'h004, 32'd0, 4'hF);
        wb_read(12'h824, 32'd1, "next_period_one");

        // Back-to-back strobes, then reset during an ack.
        wb_write(12'h004, 32'd1000, 4'hF);
        wb_write(12'h100, 32'h000000F0, 4'hF);
        exp_q.push_back(32'd1); chk_q.push_back(1'b1); name_q.push_back("b2b_rd0");
        exp_q.push_back(32'd1); chk_q.push_back(1'b1); name_q.push_back("b2b_rd1");
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = ack;
        end
        @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
        check("ack_pattern", 32'(pat), 32'b1010);

        exp_q.push_back(32'd1000); chk_q.push_back(1'b1); name_q.push_back("rd_before_rst");
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h004;
        @(posedge clk); #1;
        check("ack_before_rst", 32'(ack), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ack_dropped_on_rst", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check("post_rst_bank_trigger", {trigger[30:0], bank}, 32'd0);
        wb_read(12'h000, 32'd0, "post_rst_ctrl");
        wb_read(12'h004, 32'd0, "post_rst_period");
        wb_read(12'h00C, 32'd0, "post_rst_status");
        wb_read(12'h100, 32'd0, "post_rst_mask");
        wb_read(12'h824, 32'd0, "post_rst_scaler");

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
